// File: rtl/uart_mem_bridge_pkg.sv
// Shared types and byte codes for the UART-to-RAM command bridge.
package uart_mem_bridge_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_GET_ADDR,
    ST_GET_BE,
    ST_GET_DATA,
    ST_WRITE,
    ST_READ_REQ,
    ST_READ_WAIT,
    ST_SEND_RESP,
    ST_SEND_ACK,
    ST_SEND_NAK
  } state_e;

  localparam logic [7:0] CMD_WR  = 8'h57;  // 'W'
  localparam logic [7:0] CMD_RD  = 8'h52;  // 'R'
  localparam logic [7:0] RSP_ACK = 8'h4B;  // 'K'
  localparam logic [7:0] RSP_NAK = 8'h15;

  // Number of whole bytes needed to carry a field of the given bit width.
  function automatic int bytes_for_bits(input int bits);
    return (bits + 7) / 8;
  endfunction

endpackage

// File: rtl/bridge_timeout_cnt.sv
// Inter-byte idle watchdog: reloads on clear, counts down while enabled and
// flags expiry on the idle cycle that would bring it to zero.
module bridge_timeout_cnt #(
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int W = (LIMIT < 2) ? 1 : $clog2(LIMIT + 1);

  logic [W-1:0] remain_q;

  // Remaining idle cycles before the current command is abandoned.
  always_ff @(posedge clk or negedge rst_ni) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // in the design samples pre-edge values regardless of block ordering.
    if (!rst_ni) begin
      remain_q <= '0;
    end else if (clr_i) begin
      remain_q <= W'(LIMIT);
    end else if (en_i && (remain_q != '0)) begin
      remain_q <= remain_q - W'(1);
    end
  end

  // A limit of zero disables the watchdog entirely.
  assign expire_o = (LIMIT != 0) && en_i && !clr_i && (remain_q == W'(1));

endmodule

// File: rtl/uart_mem_bridge.sv
// Parses 'W'/'R' commands from a UART byte stream, issues single-cycle
// accesses on a RAM port and returns ACK/NAK or read data on the TX stream.
module uart_mem_bridge
  import uart_mem_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000
) (
  input  logic                  clk,
  input  logic                  rst_ni,
  input  logic                  rx_valid_i,
  input  logic [7:0]            rx_data_i,
  output logic                  rx_ready_o,
  output logic                  tx_valid_o,
  output logic [7:0]            tx_data_o,
  input  logic                  tx_ready_i,
  output logic [ADDR_WIDTH-1:0] mem_addr_o,
  output logic [31:0]           mem_wdata_o,
  output logic                  mem_we_o,
  output logic [3:0]            mem_be_o,
  input  logic [31:0]           mem_rdata_i,
  output logic                  busy_o,
  output logic                  err_o
);

  localparam int ADDR_BYTES = bytes_for_bits(ADDR_WIDTH);
  localparam int AB_BITS    = ADDR_BYTES * 8;

  state_e             state_q;
  logic [2:0]         cnt_q;
  logic               is_wr_q;
  logic [AB_BITS-1:0] addr_q;
  logic [3:0]         be_q;
  logic [31:0]        data_q;
  logic [23:0]        resp_q;   // upper three read bytes still to be sent
  logic               rx_ready_q;
  logic               tx_valid_q;
  logic [7:0]         tx_data_q;
  logic               we_q;
  logic [3:0]         mem_be_q;
  logic               err_q;

  logic rx_fire;
  logic tx_fire;
  logic collecting;
  logic tmo_expire;

  assign rx_fire    = rx_valid_i & rx_ready_q;
  assign tx_fire    = tx_valid_q & tx_ready_i;
  assign collecting = state_q inside {ST_GET_ADDR, ST_GET_BE, ST_GET_DATA};

  // Watchdog only runs while a command is partially received.
  bridge_timeout_cnt #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk      (clk),
    .rst_ni   (rst_ni),
    .clr_i    (rx_fire | ~collecting),
    .en_i     (collecting & ~rx_fire),
    .expire_o (tmo_expire)
  );

  // Command FSM with all handshake and RAM strobes registered.
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      is_wr_q    <= 1'b0;
      addr_q     <= '0;
      be_q       <= '0;
      data_q     <= '0;
      resp_q     <= '0;
      rx_ready_q <= 1'b0;
      tx_valid_q <= 1'b0;
      tx_data_q  <= '0;
      we_q       <= 1'b0;
      mem_be_q   <= '0;
      err_q      <= 1'b0;
    end else begin
      we_q     <= 1'b0;
      mem_be_q <= '0;
      err_q    <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          rx_ready_q <= 1'b1;
          if (rx_fire) begin
            cnt_q <= '0;
            if ((rx_data_i == CMD_WR) || (rx_data_i == CMD_RD)) begin
              is_wr_q <= (rx_data_i == CMD_WR);
              state_q <= ST_GET_ADDR;
            end else begin
              err_q      <= 1'b1;
              tx_valid_q <= 1'b1;
              tx_data_q  <= RSP_NAK;
              rx_ready_q <= 1'b0;
              state_q    <= ST_SEND_NAK;
            end
          end
        end
        ST_GET_ADDR: begin
          if (tmo_expire) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (rx_fire) begin
            // Shift in from the top so the first (least significant) byte
            // lands at the bottom once all address bytes have arrived.
            addr_q <= (addr_q >> 8) | (AB_BITS'(rx_data_i) << (AB_BITS - 8));
            if (cnt_q == 3'(ADDR_BYTES - 1)) begin
              cnt_q <= '0;
              if (is_wr_q) begin
                state_q <= ST_GET_BE;
              end else begin
                rx_ready_q <= 1'b0;
                state_q    <= ST_READ_REQ;
              end
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_GET_BE: begin
          if (tmo_expire) begin
            err_q   <= 1'b1;
            state_q <= ST_IDLE;
          end else if (rx_fire) begin
            be_q    <= rx_data_i[3:0];
            state_q <= ST_GET_DATA;
          end
        end
        ST_GET_DATA: begin
          if (tmo_expire) begin
            err_q   <= 1'b1;
            cnt_q   <= '0;
            state_q <= ST_IDLE;
          end else if (rx_fire) begin
            data_q <= {rx_data_i, data_q[31:8]};
            if (cnt_q == 3'd3) begin
              cnt_q      <= '0;
              we_q       <= 1'b1;
              mem_be_q   <= be_q;
              rx_ready_q <= 1'b0;
              state_q    <= ST_WRITE;
            end else begin
              cnt_q <= cnt_q + 3'd1;
            end
          end
        end
        ST_WRITE: begin
          tx_valid_q <= 1'b1;
          tx_data_q  <= RSP_ACK;
          state_q    <= ST_SEND_ACK;
        end
        ST_READ_REQ: begin
          state_q <= ST_READ_WAIT;
        end
        ST_READ_WAIT: begin
          resp_q     <= mem_rdata_i[31:8];
          tx_data_q  <= mem_rdata_i[7:0];
          tx_valid_q <= 1'b1;
          cnt_q      <= '0;
          state_q    <= ST_SEND_RESP;
        end
        ST_SEND_RESP: begin
          if (tx_fire) begin
            if (cnt_q == 3'd3) begin
              tx_valid_q <= 1'b0;
              rx_ready_q <= 1'b1;
              cnt_q      <= '0;
              state_q    <= ST_IDLE;
            end else begin
              tx_data_q <= resp_q[7:0];
              resp_q    <= resp_q >> 8;
              cnt_q     <= cnt_q + 3'd1;
            end
          end
        end
        ST_SEND_ACK, ST_SEND_NAK: begin
          if (tx_fire) begin
            tx_valid_q <= 1'b0;
            rx_ready_q <= 1'b1;
            state_q    <= ST_IDLE;
          end
        end
        default: begin
          rx_ready_q <= 1'b0;
          tx_valid_q <= 1'b0;
          state_q    <= ST_IDLE;
        end
      endcase
    end
  end

  assign rx_ready_o  = rx_ready_q;
  assign tx_valid_o  = tx_valid_q;
  assign tx_data_o   = tx_data_q;
  assign mem_addr_o  = addr_q[ADDR_WIDTH-1:0];
  assign mem_wdata_o = data_q;
  assign mem_we_o    = we_q;
  assign mem_be_o    = mem_be_q;
  assign busy_o      = (state_q != ST_IDLE);
  assign err_o       = err_q;

endmodule

// File: doc/uart_mem_bridge.md
Name: uart_mem_bridge

Overview:
Command-parsing initiator that drives one port of the 32-bit byte-enabled dual-port RAM from a UART byte stream. It receives bytes from the UART RX path, decodes write/read commands, and issues single-cycle RAM accesses. It returns read data or acknowledgements on the UART TX byte stream. It sits between the UART core and RAM port B; port A remains with the core.

Parameters:
ADDR_WIDTH, 8, RAM word-address width; must match the RAM instance.
TIMEOUT_CYCLES, 1000, maximum idle cycles between bytes inside a command before abort; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_ni  in  1  asynchronous active-low reset
rx_valid_i  in  1  RX byte valid
rx_data_i  in  8  RX byte
rx_ready_o  out  1  bridge accepts RX byte this cycle
tx_valid_o  out  1  TX byte valid
tx_data_o  out  8  TX byte
tx_ready_i  in  1  TX sink accepts byte
mem_addr_o  out  ADDR_WIDTH  RAM word address
mem_wdata_o  out  32  RAM write data
mem_we_o  out  1  RAM write enable (one-cycle pulse)
mem_be_o  out  4  RAM byte enables
mem_rdata_i  in  32  RAM read data (valid the cycle after the address is presented)
busy_o  out  1  high whenever state != IDLE
err_o  out  1  one-cycle pulse on bad command or timeout

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all outputs 0; internal addr/data/be/counters 0.
- Interface: clk and rst_ni; one clock domain; reset asynchronous, active-low.
- Byte transfer: an RX byte is taken when rx_valid_i & rx_ready_o. A TX byte completes when tx_valid_o & tx_ready_i. tx_valid_o/tx_data_o hold stable until accepted.
- Derived constant: ADDR_BYTES = ceil(ADDR_WIDTH/8). Address bytes arrive LSB first; bits above ADDR_WIDTH are ignored. Data bytes arrive LSB first.
- Commands:
  - 0x57 'W', then ADDR_BYTES addr, 1 be byte (low nibble used), 4 data bytes -> write. Response 0x4B 'K'.
  - 0x52 'R', then ADDR_BYTES addr -> read. Response is 4 bytes, rdata LSB first.
  - Any other first byte -> response 0x15 (NAK), err_o pulse, back to IDLE.
- rx_ready_o=1 only in IDLE, GET_ADDR, GET_BE and GET_DATA; 0 elsewhere.
- FSM:
  - IDLE: on byte 'W' or 'R', latch opcode -> GET_ADDR. On any other byte -> SEND_NAK.
  - GET_ADDR: count ADDR_BYTES bytes. Then 'W' -> GET_BE; 'R' -> READ_REQ.
  - GET_BE: one byte -> GET_DATA.
  - GET_DATA: 4 bytes -> WRITE.
  - WRITE: mem_we_o=1, mem_be_o=be[3:0], mem_addr_o/mem_wdata_o driven for exactly one cycle -> SEND_ACK. A be of 0 still issues the cycle; no byte is modified.
  - READ_REQ: drive mem_addr_o with mem_we_o=0 for one cycle -> READ_WAIT.
  - READ_WAIT: capture mem_rdata_i into a 32-bit shift register -> SEND_RESP.
  - SEND_RESP: send 4 bytes, low byte first -> IDLE after the 4th accept.
  - SEND_ACK / SEND_NAK: send one byte -> IDLE.
- Outside WRITE, mem_we_o=0 and mem_be_o=0. mem_addr_o holds the last latched address.
- Latency: write strobe occurs 1 cycle after the last data byte is accepted. Read address is presented 1 cycle after the last addr byte. Data is captured the next cycle, and tx_valid_o asserts the cycle after that.
- Timeout: in GET_ADDR, GET_BE or GET_DATA, a counter increments each cycle without an accepted byte and clears on each accept. When it reaches TIMEOUT_CYCLES: err_o pulse, partial command discarded, state -> IDLE, no TX byte, no RAM access. The counter is inactive in IDLE and in TX states, so TX backpressure never times out.
- Reset mid-command or mid-response: immediate return to IDLE. A pending TX byte is dropped and tx_valid_o=0.
- A simultaneous RX byte during TX states is not accepted (rx_ready_o=0) and must be held by the source.

Decomposition:
- Package uart_mem_bridge_pkg holds:
  - state enum typedef;
  - opcode constants CMD_WR=8'h57, CMD_RD=8'h52;
  - response constants RSP_ACK=8'h4B, RSP_NAK=8'h15.
- Sub-module: bridge_timeout_cnt (parameterised down-counter with clear/enable/expire). Everything else stays in one module.

Test Plan:
- Write: RX 57,10,0F,44,33,22,11 -> one cycle we=1, addr=0x10, be=F, wdata=0x11223344; TX 4B.
- Read-back: after the write, RX 52,10 -> one read cycle at addr 0x10, we=0; TX 44,33,22,11 in order.
- Partial byte write: RX 57,10,02,AA,BB,CC,DD -> be=2, wdata=0xDDCCBBAA. Read 0x10 returns 44,BB,22,11.
- Bad opcode: RX 0x00 -> TX 15, err_o one-cycle pulse, busy_o low next cycle, no RAM access.
- Timeout: with TIMEOUT_CYCLES=20, RX 57,10 then silence -> err_o at cycle 20 after the last accept, no we, no TX. Then RX 52,10 -> normal 4-byte read.
- Backpressure/reset: read with tx_ready_i low 50 cycles -> tx_data_o stable, no err. Assert rst_ni low mid-response -> all outputs 0 asynchronously; IDLE after release.
